// File: rtl/rf_wb_scoreboard_pkg.sv
// Shared types and constants for the register-file writeback scoreboard.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  // One writeback request as presented by an execution unit.
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

  // Select between two writeback requests (sel=1 picks b).
  function automatic wb_req_t wb_pick(input logic sel, input wb_req_t a, input wb_req_t b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/rf_wb_scoreboard_rr_arb2.sv
// Two-input round-robin arbiter. Input 0 is ALU, input 1 is LSU.
// last_lsu remembers who won the most recent conflict; the other side wins the next one.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_lsu_q;
  logic last_lsu_d;
  logic conflict;

  // Grant decode: a lone requester always wins, a conflict goes to whoever did not win last.
  always_comb begin
    conflict   = req_i[0] && req_i[1];
    gnt_o[1]   = req_i[1] && (!req_i[0] || !last_lsu_q);
    gnt_o[0]   = req_i[0] && (!req_i[1] ||  last_lsu_q);
    last_lsu_d = conflict ? gnt_o[1] : last_lsu_q;
  end

  // Priority pointer; only moves on conflict cycles so a lone request never skews fairness.
  always_ff @(posedge clk) begin
    if (!rst_n) last_lsu_q <= 1'b0;
    else        last_lsu_q <= last_lsu_d;
  end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Write-port arbiter and RAW/WAW scoreboard in front of the 32x32 register file.
// Writeback muxing is purely combinational so the register file writes on the same edge.
module rf_wb_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int NREGS = rf_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] iss_rs1,
  input  logic [REG_AW-1:0] iss_rs2,
  input  logic              iss_we,
  input  logic              iss_use1,
  input  logic              iss_use2,
  output logic              iss_ready,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              lsu_wb_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [1:0]       gnt;
  logic             hazard;
  logic             iss_fire;
  wb_req_t          alu_req;
  wb_req_t          lsu_req;
  wb_req_t          win_req;

  assign alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({lsu_req.valid, alu_req.valid}),
    .gnt_o (gnt)
  );

  // Hazard check against the registered scoreboard only; no bypass from this cycle's commit.
  always_comb begin
    hazard    = (iss_use1 && busy_q[iss_rs1]) ||
                (iss_use2 && busy_q[iss_rs2]) ||
                (iss_we   && busy_q[iss_rd]);
    iss_ready = rst_n && !hazard;
    iss_fire  = iss_valid && iss_ready;
  end

  // Writeback commit: grants are suppressed in reset so nothing is consumed then.
  always_comb begin
    alu_wb_ready = rst_n && gnt[0];
    lsu_wb_ready = rst_n && gnt[1];
    win_req      = wb_pick(gnt[1], alu_req, lsu_req);
    rf_we        = (alu_wb_ready || lsu_wb_ready) && (win_req.rd != '0);
    rf_waddr     = win_req.rd;
    rf_wdata     = win_req.data;
  end

  // x0 never becomes busy.
  always_comb busy_d[0] = 1'b0;

  // Per-register next state: an issue setting rd beats a commit clearing it in the same cycle.
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    logic set_bit;
    logic clr_bit;
    always_comb begin
      set_bit    = iss_fire && iss_we && (iss_rd == REG_AW'(gi));
      clr_bit    = rf_we && (rf_waddr == REG_AW'(gi));
      busy_d[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_q[gi]);
    end
  end

  // Scoreboard register; reset wipes all in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed, table-driven bench for rf_wb_scoreboard with a hand-written commit-latency sequence.
module tb_rf_wb_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        iss_valid, iss_we, iss_use1, iss_use2;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_ready;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int n_cmp;
  int n_bad;

  rf_wb_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iss_valid    (iss_valid),
    .iss_rd       (iss_rd),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_we       (iss_we),
    .iss_use1     (iss_use1),
    .iss_use2     (iss_use2),
    .iss_ready    (iss_ready),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, iv, iwe, iu1, iu2;
    logic [4:0]  rd, rs1, rs2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_ir, e_ar, e_lr, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[64];
  int   nv;

  task automatic add(input logic r, iv, iwe, iu1, iu2, input logic [4:0] rd, rs1, rs2,
                     input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic eir, ear, elr, ewe, input logic [4:0] ewa,
                     input logic [31:0] ewd, input logic [31:0] eb);
    vecs[nv] = '{r, iv, iwe, iu1, iu2, rd, rs1, rs2, av, ard, adat, lv, lrd, ldat,
                 eir, ear, elr, ewe, ewa, ewd, eb};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; iss_valid = v.iv; iss_we = v.iwe; iss_use1 = v.iu1; iss_use2 = v.iu2;
    iss_rd = v.rd; iss_rs1 = v.rs1; iss_rs2 = v.rs2;
    alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.adat;
    lsu_wb_valid = v.lv; lsu_wb_rd = v.lrd; lsu_wb_data = v.ldat;
  endtask

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  vec_t idle;
  int   wait_cycles;

  initial begin
    n_cmp = 0; n_bad = 0; nv = 0;
    idle = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
             32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0};
    drive(idle);
    rst_n = 1'b0;

    // reset with everything requesting
    add(0,1,1,1,1, 1,2,3, 1,2,32'h11, 1,3,32'h22, 0,0,0,0, 0,0, 0);
    add(0,1,1,1,1, 1,2,3, 1,2,32'h11, 1,3,32'h22, 0,0,0,0, 0,0, 0);
    // RAW on x5
    add(1,1,1,1,1, 5,1,2, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(1,1,0,1,0, 0,5,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, b(5));
    add(1,1,0,1,0, 0,5,0, 1,5,32'hDEADBEEF, 0,0,0, 0,1,0,1, 5,32'hDEADBEEF, b(5));
    add(1,1,0,1,0, 0,5,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    // conflict on x3 (ALU) / x7 (LSU), first conflict goes to LSU
    add(1,1,1,0,0, 3,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(1,1,1,0,0, 7,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, b(3));
    add(1,0,0,0,0, 0,0,0, 1,3,32'hA3, 1,7,32'hB7, 1,0,1,1, 7,32'hB7, b(3)|b(7));
    add(1,0,0,0,0, 0,0,0, 1,3,32'hA3, 0,0,0,     1,1,0,1, 3,32'hA3, b(3));
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    // sustained conflict, losers hold their request; LSU won last so ALU goes first
    add(1,0,0,0,0, 0,0,0, 1,11,32'hA011, 1,21,32'hB021, 1,1,0,1, 11,32'hA011, 0);
    add(1,0,0,0,0, 0,0,0, 1,12,32'hA012, 1,21,32'hB021, 1,0,1,1, 21,32'hB021, 0);
    add(1,0,0,0,0, 0,0,0, 1,12,32'hA012, 1,22,32'hB022, 1,1,0,1, 12,32'hA012, 0);
    add(1,0,0,0,0, 0,0,0, 1,13,32'hA013, 1,22,32'hB022, 1,0,1,1, 22,32'hB022, 0);
    add(1,0,0,0,0, 0,0,0, 1,13,32'hA013, 1,23,32'hB023, 1,1,0,1, 13,32'hA013, 0);
    add(1,0,0,0,0, 0,0,0, 1,14,32'hA014, 1,23,32'hB023, 1,0,1,1, 23,32'hB023, 0);
    // x0 handling
    add(1,1,1,1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(1,1,0,1,1, 0,0,0, 1,0,32'h1234, 0,0,0, 1,1,0,0, 0,0, 0);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    // WAW on x9, then same-cycle set and clear
    add(1,1,1,0,0, 9,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(1,1,1,0,0, 9,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0, b(9));
    add(1,1,1,0,0, 9,0,0, 1,9,32'h99, 0,0,0, 0,1,0,1, 9,32'h99, b(9));
    add(1,1,1,0,0, 9,0,0, 1,9,32'h77, 0,0,0, 1,1,0,1, 9,32'h77, 0);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, b(9));
    add(1,0,0,0,0, 0,0,0, 1,9,32'h55, 0,0,0, 1,1,0,1, 9,32'h55, b(9));
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    // reset mid-operation, then first conflict goes to LSU again
    add(1,1,1,0,0, 4,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(0,1,1,0,0, 8,0,0, 1,4,32'h44, 1,6,32'h66, 0,0,0,0, 0,0, b(4));
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);
    add(1,0,0,0,0, 0,0,0, 1,1,32'h1, 1,2,32'h2, 1,0,1,1, 2,32'h2, 0);
    add(1,0,0,0,0, 0,0,0, 1,1,32'h1, 0,0,0,   1,1,0,1, 1,32'h1, 0);
    add(1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 0,0, 0);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.iss_ready", i), 32'(iss_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d.alu_ready", i), 32'(alu_wb_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d.lsu_ready", i), 32'(lsu_wb_ready), 32'(vecs[i].e_lr));
      chk($sformatf("v%0d.rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d.waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
        chk($sformatf("v%0d.wdata", i), rf_wdata, vecs[i].e_wd);
      end
      chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      $display("vec %0d: rdy=%0b alu_rdy=%0b lsu_rdy=%0b we=%0b wa=%0d wd=%08h busy=%08h",
               i, iss_ready, alu_wb_ready, lsu_wb_ready, rf_we, rf_waddr, rf_wdata, busy);
    end

    // Hand sequence: reader of x15 stalls through the commit cycle, issues the next one.
    @(negedge clk);
    drive(idle); iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd15;
    @(negedge clk);
    drive(idle); iss_valid = 1'b1; iss_use2 = 1'b1; iss_rs2 = 5'd15;
    #1 chk("seq.stall_before_commit", 32'(iss_ready), 32'd0);
    @(negedge clk);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd15; alu_wb_data = 32'hCAFE0015;
    #1 chk("seq.stall_in_commit", 32'(iss_ready), 32'd0);
    chk("seq.commit_we", 32'(rf_we), 32'd1);
    wait_cycles = 0;
    @(negedge clk);
    alu_wb_valid = 1'b0;
    #1;
    while (!iss_ready && wait_cycles < 4) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    chk("seq.release_latency", 32'(wait_cycles), 32'd0);
    chk("seq.release_ready", 32'(iss_ready), 32'd1);
    $display("seq x15: released after %0d extra cycles, busy=%08h", wait_cycles, busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
